// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: accepts one addition request at a time, drives the FPU
// adder through its start / operand / result handshake, and returns the sum
// with the originating tag. A per-state watchdog resets a stalled adder and
// answers with a quiet NaN flagged as an error.
module fpu_add_sequencer #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic             clk,
    input  logic             rst,
    // request interface
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    // response interface
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_z,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    // adder interface
    output logic             add_start,
    output logic             add_rst,
    input  logic             add_idle_status,
    output logic [31:0]      add_input_a,
    output logic             add_input_a_stb,
    input  logic             add_input_a_ack,
    output logic [31:0]      add_input_b,
    output logic             add_input_b_stb,
    input  logic             add_input_b_ack,
    input  logic [31:0]      add_output_z,
    input  logic             add_output_z_stb,
    input  logic             add_output_valid,
    output logic             add_ack_output,
    // statistics
    output logic [15:0]      txn_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED_A,
        S_FEED_B,
        S_WAIT_Z,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    // Quiet NaN returned when the watchdog aborts a transaction.
    localparam logic [31:0]     ABORT_NAN = 32'h7FC0_0000;
    // Last watchdog count before an abort fires.
    localparam logic [TO_W-1:0] WD_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              handshake;
    logic              in_adder;
    logic              wd_expired;
    logic [TO_W-1:0]   wd_count;
    logic [31:0]       a_q;
    logic [31:0]       b_q;

    // Moore decode of the handshake outputs from the state register.
    assign req_ready       = (state == S_IDLE) && !add_rst;
    assign add_start       = (state == S_START);
    assign add_input_a_stb = (state == S_FEED_A);
    assign add_input_b_stb = (state == S_FEED_B);
    assign add_ack_output  = (state == S_WAIT_Z) || (state == S_WAIT_DONE);
    assign res_valid       = (state == S_RESP);
    assign add_input_a     = a_q;
    assign add_input_b     = b_q;

    // States in which the adder owns progress and the watchdog is armed.
    assign in_adder = (state != S_IDLE) && (state != S_RESP);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a completed handshake always beats a watchdog expiry.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        handshake  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) state_next = S_START;
            end
            S_START: begin
                if (add_idle_status) begin
                    state_next = S_FEED_A;
                    handshake  = 1'b1;
                end
            end
            S_FEED_A: begin
                if (add_input_a_ack) begin
                    state_next = S_FEED_B;
                    handshake  = 1'b1;
                end
            end
            S_FEED_B: begin
                if (add_input_b_ack) begin
                    state_next = S_WAIT_Z;
                    handshake  = 1'b1;
                end
            end
            S_WAIT_Z: begin
                if (add_output_z_stb) begin
                    state_next = S_WAIT_DONE;
                    handshake  = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (add_output_valid) begin
                    state_next = S_RESP;
                    handshake  = 1'b1;
                end
            end
            S_RESP: begin
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        wd_expired = in_adder && !handshake && (wd_count == WD_LAST);
        if (wd_expired) state_next = S_RESP;
    end

    // Watchdog: counts cycles spent in one adder-facing state, clears on any change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_count <= '0;
        end else if (!in_adder || (state_next != state)) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 1'b1;
        end
    end

    // Adder reset: held through our own reset plus one edge, and pulsed on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_rst <= 1'b1;
        end else begin
            add_rst <= wd_expired;
        end
    end

    // Operand, tag, result and error registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: these are plain flops, not a memory, so they take the reset
        // and a discarded transaction leaves nothing stale on the outputs.
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_tag <= '0;
            res_z   <= '0;
            res_err <= 1'b0;
        end else begin
            if ((state == S_IDLE) && req_valid && req_ready) begin
                a_q     <= req_a;
                b_q     <= req_b;
                res_tag <= req_tag;
            end
            if ((state == S_WAIT_Z) && add_output_z_stb) begin
                res_z <= add_output_z;
            end
            if (wd_expired) begin
                res_z   <= ABORT_NAN;
                res_err <= 1'b1;
            end else if ((state == S_RESP) && res_ready) begin
                res_err <= 1'b0;
            end
        end
    end

    // Completed-operation counter; aborts are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txn_count <= '0;
        end else if ((state == S_WAIT_DONE) && add_output_valid) begin
            txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Directed testbench for fpu_add_sequencer with a behavioural adder model.
module tb_fpu_add_sequencer;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_z;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             add_start;
    logic             add_rst;
    logic             add_idle_status;
    logic [31:0]      add_input_a;
    logic             add_input_a_stb;
    logic             add_input_a_ack;
    logic [31:0]      add_input_b;
    logic             add_input_b_stb;
    logic             add_input_b_ack;
    logic [31:0]      add_output_z;
    logic             add_output_z_stb;
    logic             add_output_valid;
    logic             add_ack_output;
    logic [15:0]      txn_count;

    int checks   = 0;
    int failures = 0;

    fpu_add_sequencer #(
        .TAG_W(TAG_W),
        .TIMEOUT_CYCLES(16),
        .TO_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_tag(req_tag),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_z(res_z),
        .res_tag(res_tag),
        .res_err(res_err),
        .add_start(add_start),
        .add_rst(add_rst),
        .add_idle_status(add_idle_status),
        .add_input_a(add_input_a),
        .add_input_a_stb(add_input_a_stb),
        .add_input_a_ack(add_input_a_ack),
        .add_input_b(add_input_b),
        .add_input_b_stb(add_input_b_stb),
        .add_input_b_ack(add_input_b_ack),
        .add_output_z(add_output_z),
        .add_output_z_stb(add_output_z_stb),
        .add_output_valid(add_output_valid),
        .add_ack_output(add_ack_output),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural adder model ----------------
    typedef enum logic [2:0] {M_IDLE, M_A, M_B, M_CALC, M_Z, M_DONE} m_state_t;
    m_state_t    m_state = M_IDLE;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_z = '0;
    int          m_cnt = 0;
    bit          no_b_ack = 1'b0;

    // Known sums for the ordered operand pairs this bench uses.
    function automatic logic [31:0] sum_lookup(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'hBF80_0000, 32'h3F80_0000}: return 32'h0000_0000;
            {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;
            {32'h40A0_0000, 32'h4040_0000}: return 32'h4100_0000;
            {32'h3F80_0000, 32'h4040_0000}: return 32'h4080_0000;
            {32'h4000_0000, 32'h4040_0000}: return 32'h40A0_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign add_idle_status  = (m_state == M_IDLE);
    assign add_input_a_ack  = (m_state == M_A);
    assign add_input_b_ack  = (m_state == M_B) && !no_b_ack;
    assign add_output_z_stb = (m_state == M_Z);
    assign add_output_valid = (m_state == M_DONE);
    assign add_output_z     = m_z;

    // Adder handshake model with a three-cycle compute latency.
    always @(posedge clk) begin
        if (add_rst) begin
            m_state <= M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (add_start) m_state <= M_A;
                M_A: if (add_input_a_stb) begin
                    m_a     <= add_input_a;
                    m_state <= M_B;
                end
                M_B: if (add_input_b_stb && add_input_b_ack) begin
                    m_b     <= add_input_b;
                    m_cnt   <= 0;
                    m_state <= M_CALC;
                end
                M_CALC: if (m_cnt == 2) begin
                    m_z     <= sum_lookup(m_a, m_b);
                    m_state <= M_Z;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                M_Z:    if (add_ack_output) m_state <= M_DONE;
                M_DONE: if (add_ack_output) m_state <= M_IDLE;
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // ---------------- drivers ----------------
    // Present a request (called at a negedge) and hold it until accepted.
    task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag, input bit keep_valid);
        int n = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_accept tag=%0d: req_ready=%b, required 1 within 200 cycles", tag, req_ready);
        end
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    // Wait (bounded) for a response and capture it at a negedge.
    task automatic wait_resp(output logic [31:0] z, output logic [TAG_W-1:0] tag,
                             output logic err, output bit got);
        int n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = (res_valid === 1'b1);
        z   = res_z;
        tag = res_tag;
        err = res_err;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({add_rst, req_ready, res_valid, res_err, add_start, add_ack_output} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 100000", {add_rst, req_ready, res_valid, res_err, add_start, add_ack_output});
        end
        checks++;
        if ({txn_count, res_z, res_tag, add_input_a, add_input_b} !== '0) begin
            failures++;
            $display("FAIL reset_data: txn=%h z=%h tag=%h a=%h b=%h, required all 0", txn_count, res_z, res_tag, add_input_a, add_input_b);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (add_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_add_rst: got %b, required 1", add_rst);
        end
        @(negedge clk);
        checks++;
        if ({add_rst, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_after_edge: add_rst,req_ready=%b, required 01", {add_rst, req_ready});
        end
    endtask

    task automatic test_basic_add(input logic [31:0] a, input logic [31:0] b,
                                  input logic [TAG_W-1:0] tag, input logic [31:0] exp_z,
                                  input logic [15:0] exp_cnt);
        logic [31:0] z;
        logic [TAG_W-1:0] t;
        logic e;
        bit got;
        res_ready = 1'b1;
        send_req(a, b, tag, 1'b0);
        wait_resp(z, t, e, got);
        checks++;
        if (!got || z !== exp_z || t !== tag || e !== 1'b0) begin
            failures++;
            $display("FAIL add_resp tag=%0d: got valid=%b z=%h tag=%0d err=%b, required 1 %h %0d 0", tag, got, z, t, e, exp_z, tag);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_single_pulse tag=%0d: res_valid=%b, required 0", tag, res_valid);
        end
        checks++;
        if (txn_count !== exp_cnt) begin
            failures++;
            $display("FAIL add_txn_count tag=%0d: got %0d, required %0d", tag, txn_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] z;
        logic [TAG_W-1:0] t;
        logic e;
        bit got;
        res_ready = 1'b0;
        send_req(32'h4000_0000, 32'h4000_0000, 4'd7, 1'b0);
        wait_resp(z, t, e, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bp_resp: no response within bound, required res_valid=1");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, req_ready, res_err, res_tag, res_z} !== {1'b1, 1'b0, 1'b0, 4'd7, 32'h4080_0000}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d: valid=%b ready=%b err=%b tag=%0d z=%h, required 1 0 0 7 40800000", i, res_valid, req_ready, res_err, res_tag, res_z);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({res_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: res_valid,req_ready=%b, required 01", {res_valid, req_ready});
        end
        checks++;
        if (txn_count !== 16'd3) begin
            failures++;
            $display("FAIL bp_txn_count: got %0d, required 3", txn_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_z [3];
        int extra = 0;
        exp_z[0] = 32'h4000_0000;
        exp_z[1] = 32'h4080_0000;
        exp_z[2] = 32'h4100_0000;
        res_ready = 1'b1;
        fork
            begin
                send_req(32'h3F80_0000, 32'h3F80_0000, 4'd0, 1'b1);
                send_req(32'h4040_0000, 32'h3F80_0000, 4'd1, 1'b1);
                send_req(32'h40A0_0000, 32'h4040_0000, 4'd2, 1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    logic [31:0] z;
                    logic [TAG_W-1:0] t;
                    logic e;
                    bit got;
                    wait_resp(z, t, e, got);
                    checks++;
                    if (!got || t !== TAG_W'(i) || z !== exp_z[i] || e !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_resp idx=%0d: got valid=%b tag=%0d z=%h err=%b, required 1 %0d %h 0", i, got, t, z, e, i, exp_z[i]);
                    end
                    @(negedge clk);
                end
            end
        join
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL b2b_no_duplicate: %0d extra response cycles, required 0", extra);
        end
        checks++;
        if (txn_count !== 16'd6) begin
            failures++;
            $display("FAIL b2b_txn_count: got %0d, required 6", txn_count);
        end
    endtask

    task automatic test_watchdog();
        int n = 0;
        int stb_cycles = 0;
        no_b_ack  = 1'b1;
        res_ready = 1'b1;
        send_req(32'h3F80_0000, 32'h4000_0000, 4'd9, 1'b0);
        while (!add_input_b_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (add_input_b_stb !== 1'b1) begin
            failures++;
            $display("FAIL wd_reach_feed_b: add_input_b_stb=%b, required 1", add_input_b_stb);
        end
        while (add_input_b_stb && stb_cycles < 100) begin
            stb_cycles++;
            @(negedge clk);
        end
        checks++;
        if (stb_cycles != 16) begin
            failures++;
            $display("FAIL wd_feed_b_cycles: got %0d, required 16", stb_cycles);
        end
        checks++;
        if ({add_rst, res_valid, res_err, res_tag, res_z} !== {1'b1, 1'b1, 1'b1, 4'd9, 32'h7FC0_0000}) begin
            failures++;
            $display("FAIL wd_abort: add_rst=%b valid=%b err=%b tag=%0d z=%h, required 1 1 1 9 7fc00000", add_rst, res_valid, res_err, res_tag, res_z);
        end
        no_b_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({add_rst, res_valid, res_err} !== 3'b000) begin
            failures++;
            $display("FAIL wd_after_abort: add_rst,res_valid,res_err=%b, required 000", {add_rst, res_valid, res_err});
        end
        checks++;
        if (txn_count !== 16'd6) begin
            failures++;
            $display("FAIL wd_txn_count: got %0d, required 6", txn_count);
        end
        test_basic_add(32'h3F80_0000, 32'h4040_0000, 4'd10, 32'h4080_0000, 16'd7);
    endtask

    task automatic test_reset_mid_txn();
        int n = 0;
        int seen = 0;
        res_ready = 1'b1;
        send_req(32'h3F80_0000, 32'h3F80_0000, 4'd4, 1'b0);
        while (!add_input_b_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (!add_ack_output && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (add_ack_output !== 1'b1) begin
            failures++;
            $display("FAIL rmid_reach_wait_z: add_ack_output=%b, required 1", add_ack_output);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({add_rst, req_ready, res_valid, res_err, add_start, add_input_a_stb, add_input_b_stb, add_ack_output} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL rmid_ctrl: got %b, required 10000000", {add_rst, req_ready, res_valid, res_err, add_start, add_input_a_stb, add_input_b_stb, add_ack_output});
        end
        checks++;
        if ({txn_count, res_z, res_tag, add_input_a, add_input_b} !== '0) begin
            failures++;
            $display("FAIL rmid_data: txn=%h z=%h tag=%h a=%h b=%h, required all 0", txn_count, res_z, res_tag, add_input_a, add_input_b);
        end
        repeat (2) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({add_rst, req_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rmid_release: add_rst,req_ready=%b, required 10", {add_rst, req_ready});
        end
        @(negedge clk);
        if (res_valid) seen++;
        checks++;
        if ({add_rst, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rmid_after_edge: add_rst,req_ready=%b, required 01", {add_rst, req_ready});
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rmid_no_response: %0d response cycles, required 0", seen);
        end
        test_basic_add(32'h4000_0000, 32'h4040_0000, 4'd11, 32'h40A0_0000, 16'd1);
    endtask

    initial begin
        test_reset();
        test_basic_add(32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 16'd1);
        test_basic_add(32'hBF80_0000, 32'h3F80_0000, 4'd5, 32'h0000_0000, 16'd2);
        test_backpressure();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_txn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

endmodule
